// File: rtl/systolic_feeder.sv
// systolic_feeder: skews A/B K-slices onto systolic array edges and sequences PE load/drain/done; SYSTOLIC_FEEDER_STALL_CNT_EN adds stall_cycles.
module systolic_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int ARRAY_DIM  = 4,
  parameter int K_WIDTH    = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [K_WIDTH-1:0]              k_len,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] a_vec,
  input  logic [ARRAY_DIM*DATA_WIDTH-1:0] b_vec,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] a_lane,
  output logic [ARRAY_DIM*DATA_WIDTH-1:0] b_lane,
  output logic                            load,
  output logic                            busy,
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  output logic                            done,
  output logic [15:0]                     stall_cycles
`else
  output logic                            done
`endif
);
  localparam int CW = K_WIDTH + 5;
  localparam logic [CW-1:0] FL = CW'(2 * ARRAY_DIM - 2);
  typedef enum logic [2:0] {IDLE, ACC, LD, DRAIN, DONE} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [K_WIDTH-1:0] kr, kr_d;
  logic shift, feed;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    kr_d = kr;
    shift = 1'b0;
    feed = cnt < {5'b0, kr};
    case (state)
      IDLE: if (start) begin
        kr_d = k_len;
        cnt_d = '0;
        state_d = (k_len == '0) ? DONE : ACC;
      end
      ACC: if (!feed || in_valid) begin
        state_d = LD;
        cnt_d = cnt + 1'b1;
        shift = 1'b1;
      end
      LD: state_d = (cnt < {5'b0, kr} + FL) ? ACC : DRAIN;
      DRAIN: state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      kr <= '0;
      load <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      in_ready <= 1'b0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      kr <= kr_d;
      load <= state_d == LD;
      busy <= state_d != IDLE;
      done <= state_d == DONE;
      in_ready <= (state_d == ACC) && (cnt_d < {5'b0, kr_d});
    end
  // lane i is a chain of i+1 registers; flush steps push zeros in
  for (genvar i = 0; i < ARRAY_DIM; i++) begin : g_lane
    logic [DATA_WIDTH-1:0] sa [i+1];
    logic [DATA_WIDTH-1:0] sb [i+1];
    always_ff @(posedge clk)
      if (rst) begin
        for (int j = 0; j <= i; j++) begin
          sa[j] <= '0;
          sb[j] <= '0;
        end
      end else if (shift) begin
        sa[0] <= feed ? a_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        sb[0] <= feed ? b_vec[i*DATA_WIDTH +: DATA_WIDTH] : '0;
        for (int j = 1; j <= i; j++) begin
          sa[j] <= sa[j-1];
          sb[j] <= sb[j-1];
        end
      end
    assign a_lane[i*DATA_WIDTH +: DATA_WIDTH] = sa[i];
    assign b_lane[i*DATA_WIDTH +: DATA_WIDTH] = sb[i];
  end
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  always_ff @(posedge clk)
    if (rst || (state == IDLE && start))
      stall_cycles <= '0;
    else if (state == ACC && feed && !in_valid && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 1'b1;
`endif
endmodule

// File: tb/tb_systolic_feeder.sv
// tb_systolic_feeder: directed checks of systolic_feeder sequencing, skew, stall, zero and reset behaviour.
module tb_systolic_feeder;
  localparam int W = 128;
  logic clk = 1'b0;
  logic rst, start, in_valid, in_ready, load, busy, done;
  logic [7:0] k_len;
  logic [W-1:0] a_vec, b_vec, a_lane, b_lane;
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif
  int checks = 0;
  int errors = 0;
  logic [W-1:0] sa [4];
  logic [W-1:0] sb [4];
  logic [W-1:0] la [64];
  logic [W-1:0] lb [64];
  logic ld [64];
  logic dn [64];
  logic bz [64];
  logic ir [64];

  systolic_feeder dut (
    .clk(clk), .rst(rst), .start(start), .k_len(k_len), .in_valid(in_valid),
    .in_ready(in_ready), .a_vec(a_vec), .b_vec(b_vec), .a_lane(a_lane),
    .b_lane(b_lane), .load(load), .busy(busy),
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    .done(done), .stall_cycles(stall_cycles)
`else
    .done(done)
`endif
  );

  always #5 clk = ~clk;

  task automatic run(input int k, input int stall_n, input int poke, input int rst_at,
                     output int done_cyc, output int nload, output int ndone);
    int c, s, st;
    logic rdy;
    s = 0; st = 0; c = 0; rdy = 1'b0;
    done_cyc = -1; nload = 0; ndone = 0;
    for (int i = 0; i < 64; i++) begin
      la[i] = '0; lb[i] = '0; ld[i] = 1'b0; dn[i] = 1'b0; bz[i] = 1'b0; ir[i] = 1'b0;
    end
    start = 1'b1; k_len = 8'(k); in_valid = 1'b1; a_vec = sa[0]; b_vec = sb[0];
    while (c < 60 && done_cyc < 0) begin
      @(posedge clk); #1;
      if (in_valid && rdy) s++;
      c++;
      start = (c == poke);
      if (c == poke) k_len = 8'd0;
      rst = (c == rst_at);
      la[c] = a_lane; lb[c] = b_lane; ld[c] = load; dn[c] = done; bz[c] = busy; ir[c] = in_ready;
      if (load) nload++;
      if (done) begin ndone++; done_cyc = c; end
      rdy = in_ready;
      if (s == 1 && rdy && st < stall_n) begin in_valid = 1'b0; st++; end
      else in_valid = 1'b1;
      a_vec = sa[s < 4 ? s : 3]; b_vec = sb[s < 4 ? s : 3];
    end
    start = 1'b0; rst = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; k_len = '0; a_vec = '1; b_vec = '1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    checks++; if (load !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_load_done got %b%b want 00", load, done); end
    checks++; if (a_lane !== '0 || b_lane !== '0) begin errors++; $display("FAIL reset_lanes got %h %h want 0", a_lane, b_lane); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    int dc, nl, nd, bad;
    sa[0] = {32'd4, 32'd3, 32'd2, 32'd1}; sb[0] = {32'd8, 32'd7, 32'd6, 32'd5};
    run(1, 0, -1, -1, dc, nl, nd);
    bad = 0;
    for (int c = 1; c <= 16; c++) if (ld[c] !== (c >= 2 && c <= 14 && c % 2 == 0)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL single_load_pattern got %0d bad cycles want 0", bad); end
    checks++; if (nl != 7) begin errors++; $display("FAIL single_load_count got %0d want 7", nl); end
    checks++; if (dc != 16 || nd != 1) begin errors++; $display("FAIL single_done got cycle %0d count %0d want 16 1", dc, nd); end
    checks++; if (la[2] !== {32'd0, 32'd0, 32'd0, 32'd1}) begin errors++; $display("FAIL single_a2 got %h", la[2]); end
    checks++; if (la[3] !== la[2]) begin errors++; $display("FAIL single_hold got %h want %h", la[3], la[2]); end
    checks++; if (la[4] !== {32'd0, 32'd0, 32'd2, 32'd0}) begin errors++; $display("FAIL single_a4 got %h", la[4]); end
    checks++; if (la[8] !== {32'd4, 32'd0, 32'd0, 32'd0} || lb[8][127:96] !== 32'd8) begin errors++; $display("FAIL single_lane3 got %h %h", la[8], lb[8]); end
    checks++; if (la[14] !== '0 || lb[14] !== '0) begin errors++; $display("FAIL single_flush got %h %h want 0", la[14], lb[14]); end
    checks++; if (bz[15] !== 1'b1 || ld[15] !== 1'b0 || ir[1] !== 1'b1) begin errors++; $display("FAIL single_drain got busy %b load %b rdy %b", bz[15], ld[15], ir[1]); end
  endtask

  task automatic test_stall;
    int dc, nl, nd, bad;
    sa[0] = {32'h04, 32'h03, 32'h02, 32'h01}; sb[0] = {32'h08, 32'h07, 32'h06, 32'h05};
    sa[1] = {32'h14, 32'h13, 32'h12, 32'h11}; sb[1] = {32'h18, 32'h17, 32'h16, 32'h15};
    sa[2] = {32'h24, 32'h23, 32'h22, 32'h21}; sb[2] = {32'h28, 32'h27, 32'h26, 32'h25};
    run(3, 3, -1, -1, dc, nl, nd);
    bad = 0;
    for (int c = 3; c <= 6; c++) if (ld[c] !== 1'b0 || la[c] !== la[2] || lb[c] !== lb[2]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_hold got %0d bad cycles want 0", bad); end
    checks++; if (dc != 23 || nl != 9) begin errors++; $display("FAIL stall_done got cycle %0d loads %0d want 23 9", dc, nl); end
    checks++; if (la[7] !== {32'h0, 32'h0, 32'h02, 32'h11}) begin errors++; $display("FAIL stall_a7 got %h", la[7]); end
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    checks++; if (stall_cycles !== 16'd3) begin errors++; $display("FAIL stall_cnt got %0d want 3", stall_cycles); end
`endif
    run(3, 0, -1, -1, dc, nl, nd);
    checks++; if (dc != 20 || nl != 9) begin errors++; $display("FAIL nostall_done got cycle %0d loads %0d want 20 9", dc, nl); end
`ifdef SYSTOLIC_FEEDER_STALL_CNT_EN
    checks++; if (stall_cycles !== 16'd0) begin errors++; $display("FAIL stall_cnt_clear got %0d want 0", stall_cycles); end
`endif
  endtask

  task automatic test_zero;
    int dc, nl, nd;
    run(0, 0, -1, -1, dc, nl, nd);
    checks++; if (dc != 1 || nl != 0 || nd != 1) begin errors++; $display("FAIL zero_k got cycle %0d loads %0d dones %0d want 1 0 1", dc, nl, nd); end
    sa[0] = {32'h0, 32'hFFFFFFFF, 32'h0, 32'h0}; sb[0] = {32'h0, 32'h0, 32'h0, 32'h9};
    run(1, 0, -1, -1, dc, nl, nd);
    checks++; if (la[2][31:0] !== 32'h0 || lb[2][31:0] !== 32'h9) begin errors++; $display("FAIL zero_elem got %h %h want 0 9", la[2][31:0], lb[2][31:0]); end
    checks++; if (la[6][95:64] !== 32'hFFFFFFFF) begin errors++; $display("FAIL zero_pass got %h want ffffffff", la[6][95:64]); end
    checks++; if (dc != 16) begin errors++; $display("FAIL zero_done got %0d want 16", dc); end
  endtask

  task automatic test_mid_reset;
    int dc, nl, nd;
    sa[0] = {32'd4, 32'd3, 32'd2, 32'd1}; sb[0] = {32'd8, 32'd7, 32'd6, 32'd5};
    run(4, 0, -1, 8, dc, nl, nd);
    checks++; if (bz[9] !== 1'b0 || ir[9] !== 1'b0 || ld[9] !== 1'b0) begin errors++; $display("FAIL midrst_idle got busy %b rdy %b load %b want 000", bz[9], ir[9], ld[9]); end
    checks++; if (la[9] !== '0 || lb[9] !== '0) begin errors++; $display("FAIL midrst_lanes got %h %h want 0", la[9], lb[9]); end
    checks++; if (nd != 0) begin errors++; $display("FAIL midrst_done got %0d dones want 0", nd); end
    run(1, 0, -1, -1, dc, nl, nd);
    checks++; if (dc != 16 || nl != 7) begin errors++; $display("FAIL midrst_rerun got cycle %0d loads %0d want 16 7", dc, nl); end
  endtask

  task automatic test_start_busy;
    int dc, nl, nd, extra;
    run(1, 0, 5, -1, dc, nl, nd);
    checks++; if (dc != 16 || nd != 1 || nl != 7) begin errors++; $display("FAIL busy_start got cycle %0d dones %0d loads %0d want 16 1 7", dc, nd, nl); end
    extra = 0;
    repeat (4) begin @(posedge clk); #1; if (done !== 1'b0 || busy !== 1'b0) extra++; end
    checks++; if (extra != 0) begin errors++; $display("FAIL busy_after got %0d active cycles want 0", extra); end
  endtask

  initial begin
    test_reset;
    test_single;
    test_stall;
    test_zero;
    test_mid_reset;
    test_start_busy;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
